// File: rtl/move_collector_if.sv
// Column-FIFO drain bus and downstream move handshake shared by move_collector and its environment.
interface move_collector_if #(
  parameter int unsigned NCOL = 8,
  parameter int unsigned MW   = 19
);
  logic [NCOL-1:0]    col_done;
  logic [NCOL-1:0]    col_empty;
  logic [NCOL*MW-1:0] col_data;
  logic [NCOL-1:0]    col_rden;
  logic               move_valid;
  logic               move_ready;
  logic [MW-1:0]      move_data;

  modport master (
    input  col_done, col_empty, col_data, move_ready,
    output col_rden, move_valid, move_data
  );

  modport slave (
    output col_done, col_empty, col_data, move_ready,
    input  col_rden, move_valid, move_data
  );
endinterface

// File: rtl/move_collector.sv
// Round-robin drain of per-column move FIFOs into a single registered move stream,
// dropping invalid words and retiring each column on its from==to end marker.
module move_collector #(
  parameter int unsigned NCOL = 8,
  parameter int unsigned MW   = 19
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  move_collector_if.master        bus,
  output logic [7:0]              move_count,
  output logic                    overflow,
  output logic                    done
);
  localparam int unsigned PW      = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int unsigned CW      = 8;
  localparam int unsigned SQW     = 6;
  localparam int unsigned INV_BIT = MW - 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SCAN, READ, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [NCOL-1:0] finished;

  logic [MW-1:0]   head;
  logic            head_empty;
  logic            is_marker;
  logic            is_invalid;
  logic            out_free;
  logic            accept;
  logic            pop_c;
  logic            load_c;
  logic [PW-1:0]   ptr_next;

  // Head-of-column decode and the pop/load decision for the current pointer.
  always_comb begin
    head       = '0;
    head_empty = 1'b1;
    for (int unsigned i = 0; i < NCOL; i++) begin
      if (ptr == PW'(i)) begin
        head       = bus.col_data[i*MW +: MW];
        head_empty = bus.col_empty[i];
      end
    end
    is_marker  = (head[2*SQW-1:SQW] == head[SQW-1:0]);
    is_invalid = head[INV_BIT];
    accept     = bus.move_valid & bus.move_ready;
    out_free   = ~bus.move_valid | bus.move_ready;
    pop_c      = 1'b0;
    load_c     = 1'b0;
    if (state == READ && !head_empty) begin
      pop_c  = is_marker | is_invalid | out_free;
      load_c = ~is_marker & ~is_invalid & out_free;
    end
    ptr_next     = (ptr == PW'(NCOL - 1)) ? '0 : ptr + PW'(1);
    bus.col_rden = pop_c ? (NCOL'(1) << ptr) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      ptr            <= '0;
      finished       <= '0;
      bus.move_valid <= 1'b0;
      bus.move_data  <= '0;
      move_count     <= '0;
      overflow       <= 1'b0;
      done           <= 1'b0;
    end else begin
      // Output register: drain on acceptance, refill from the popped head word.
      if (accept) begin
        bus.move_valid <= 1'b0;
        if (move_count == CNT_MAX) begin
          overflow <= 1'b1;
        end else begin
          move_count <= move_count + CW'(1);
        end
      end
      if (load_c) begin
        bus.move_valid <= 1'b1;
        bus.move_data  <= head;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SCAN;
            ptr        <= '0;
            finished   <= '0;
            move_count <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
          end
        end
        SCAN: begin
          if (&finished) begin
            // Hold off completion until the last move has left the output register.
            if (!bus.move_valid) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (bus.col_done[ptr] && !bus.col_empty[ptr] && !finished[ptr]) begin
            state <= READ;
          end else begin
            ptr <= ptr_next;
          end
        end
        READ: begin
          if (!head_empty && is_marker) begin
            finished[ptr] <= 1'b1;
            ptr           <= ptr_next;
            state         <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_move_collector.sv
// Randomized scoreboard bench for move_collector: queue-based column FIFOs feed the DUT,
// expected moves per column are queued at load time and popped by an output monitor.
`timescale 1ns/1ps
module tb_move_collector;
  localparam int unsigned NCOL = 8;
  localparam int unsigned MW   = 19;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] move_count;
  logic       overflow;
  logic       done;

  move_collector_if #(.NCOL(NCOL), .MW(MW)) bus ();

  move_collector #(.NCOL(NCOL), .MW(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .move_count (move_count),
    .overflow   (overflow),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [MW-1:0] fifo [NCOL][$];
  logic [MW-1:0] expq [NCOL][$];
  int   ready_mode   = 0;
  logic manual_ready = 1'b0;
  bit   strict       = 1'b1;
  int   cur          = -1;
  int   pop_cnt      = 0;
  int   serial       = 0;
  bit   held         = 1'b0;
  logic [MW-1:0] held_data;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic bit is_move(logic [MW-1:0] w);
    return !w[MW-1] && (w[11:6] != w[5:0]);
  endfunction

  function automatic logic [MW-1:0] mk_valid();
    logic [5:0] f;
    logic [5:0] t;
    f = 6'(serial);
    t = f ^ 6'($urandom_range(1, 63));
    serial++;
    return {1'b0, 6'($urandom), f, t};
  endfunction

  function automatic logic [MW-1:0] mk_invalid();
    logic [5:0] f;
    logic [5:0] t;
    f = 6'($urandom);
    t = f ^ 6'($urandom_range(1, 63));
    return {1'b1, 6'($urandom), f, t};
  endfunction

  function automatic logic [MW-1:0] mk_marker();
    logic [5:0] f;
    f = 6'($urandom);
    return {1'b0, 6'($urandom), f, f};
  endfunction

  function automatic void clear_all();
    for (int i = 0; i < NCOL; i++) begin
      fifo[i].delete();
      expq[i].delete();
    end
    cur    = -1;
    held   = 1'b0;
    serial = 0;
  endfunction

  // Column contents: nv legal moves and ni invalid words shuffled, then an end marker.
  function automatic void load_col(int c, int nv, int ni);
    logic [MW-1:0] w;
    int v;
    int n;
    v = nv;
    n = ni;
    while (v + n > 0) begin
      if (n > 0 && (v == 0 || $urandom_range(0, 2) == 0)) begin
        fifo[c].push_back(mk_invalid());
        n--;
      end else begin
        w = mk_valid();
        fifo[c].push_back(w);
        expq[c].push_back(w);
        v--;
      end
    end
    fifo[c].push_back(mk_marker());
  endfunction

  function automatic void refresh();
    for (int i = 0; i < NCOL; i++) begin
      bus.col_empty[i] = (fifo[i].size() == 0);
      bus.col_data[i*MW +: MW] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  endfunction

  // First-word-fall-through column FIFOs: pop on the edge where col_rden was high.
  initial begin : column_model
    logic [NCOL-1:0] rq;
    refresh();
    forever begin
      @(negedge clk);
      rq = bus.col_rden;
      if (rq != '0) begin
        chk("rden_onehot", 32'($countones(rq)), 32'd1);
        for (int i = 0; i < NCOL; i++) begin
          if (rq[i]) begin
            chk("rden_nonempty", 32'(fifo[i].size() != 0), 32'd1);
            if (fifo[i].size() != 0 && bus.move_valid && !bus.move_ready)
              chk("pop_move_while_held", 32'(is_move(fifo[i][0])), 32'd0);
          end
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NCOL; i++) begin
        if (rq[i] && fifo[i].size() != 0) begin
          void'(fifo[i].pop_front());
          pop_cnt++;
        end
      end
      refresh();
    end
  end

  initial begin : ready_driver
    bus.move_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.move_ready = 1'b1;
        1:       bus.move_ready = ($urandom_range(0, 3) != 0);
        default: bus.move_ready = manual_ready;
      endcase
    end
  end

  // Output monitor: held words must not change, accepted words come from the scoreboard.
  always @(negedge clk) begin : monitor
    int c;
    if (reset) begin
      if (held) begin
        chk("hold_valid", 32'(bus.move_valid), 32'd1);
        chk("hold_data", 32'(bus.move_data), 32'(held_data));
      end
      held      = bus.move_valid && !bus.move_ready;
      held_data = bus.move_data;
      if (bus.move_valid && bus.move_ready) begin
        c = -1;
        if (cur >= 0 && expq[cur].size() != 0) begin
          c = cur;
        end else begin
          for (int i = 0; i < NCOL; i++)
            if (c < 0 && expq[i].size() != 0 && (strict || expq[i][0] == bus.move_data))
              c = i;
        end
        if (c < 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_move actual=%0h required=none", bus.move_data);
        end else begin
          chk("move_data", 32'(bus.move_data), 32'(expq[c].pop_front()));
          cur = c;
        end
      end
    end
  end

  task automatic start_collect(bit reverse, bit restart, output int total);
    total = 0;
    for (int i = 0; i < NCOL; i++) total += expq[i].size();
    cur = -1;
    bus.col_done = reverse ? '0 : '1;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (restart) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    if (reverse) begin
      for (int i = int'(NCOL) - 1; i >= 0; i--) begin
        bus.col_done[i] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic finish_collect(string tag, int total, output int cyc);
    int left_words;
    int left_exp;
    left_words = 0;
    left_exp   = 0;
    cyc        = 0;
    while (done !== 1'b1 && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    @(negedge clk);
    for (int i = 0; i < NCOL; i++) begin
      left_words += fifo[i].size();
      left_exp   += expq[i].size();
    end
    chk({tag, "_cols_drained"}, 32'(left_words), 32'd0);
    chk({tag, "_moves_missing"}, 32'(left_exp), 32'd0);
    chk({tag, "_valid_low"}, 32'(bus.move_valid), 32'd0);
    chk({tag, "_move_count"}, 32'(move_count), (total > 255) ? 32'd255 : 32'(total));
    chk({tag, "_overflow"}, 32'(overflow), 32'(total > 255));
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_rden"}, 32'(bus.col_rden), 32'd0);
    chk({tag, "_valid"}, 32'(bus.move_valid), 32'd0);
    chk({tag, "_data"}, 32'(bus.move_data), 32'd0);
    chk({tag, "_count"}, 32'(move_count), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin : main
    int tot;
    int cyc;
    int p0;
    bit rev;
    bus.col_done = '0;

    // Power-on reset
    #1 reset = 1'b0;
    #2 check_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("reset_release_rden", 32'(bus.col_rden), 32'd0);

    // One legal move per column, all columns ready: column order 0..7
    clear_all();
    strict = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < NCOL; i++) load_col(i, 1, 0);
    start_collect(1'b0, 1'b0, tot);
    finish_collect("one_per_col", tot, cyc);

    // Column 3: invalid word, then 0x0004A, then its marker
    clear_all();
    for (int i = 0; i < NCOL; i++) begin
      if (i == 3) begin
        fifo[3].push_back(19'h40123);
        fifo[3].push_back(19'h0004A);
        expq[3].push_back(19'h0004A);
      end
      fifo[i].push_back(mk_marker());
    end
    p0 = pop_cnt;
    start_collect(1'b0, 1'b0, tot);
    finish_collect("invalid_drop", tot, cyc);
    chk("invalid_drop_pops", 32'(pop_cnt - p0), 32'(NCOL + 2));

    // Downstream stall: output frozen, no pop until ready returns, then exactly one pop
    clear_all();
    ready_mode = 2;
    manual_ready = 1'b0;
    load_col(0, 3, 0);
    for (int i = 1; i < NCOL; i++) load_col(i, 0, 0);
    start_collect(1'b0, 1'b0, tot);
    cyc = 0;
    while (!bus.move_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_valid_seen", 32'(bus.move_valid), 32'd1);
    p0 = pop_cnt;
    repeat (5) @(negedge clk);
    chk("stall_no_pop", 32'(pop_cnt - p0), 32'd0);
    @(posedge clk);
    #1 manual_ready = 1'b1;
    @(negedge clk);
    manual_ready = 1'b0;
    @(posedge clk);
    #3 chk("stall_one_pop", 32'(pop_cnt - p0), 32'd1);
    repeat (2) @(negedge clk);
    chk("stall_one_pop_hold", 32'(pop_cnt - p0), 32'd1);
    ready_mode = 0;
    finish_collect("stall", tot, cyc);

    // Columns finish in reverse order with random contents and random back-pressure
    clear_all();
    strict = 1'b0;
    ready_mode = 1;
    for (int i = 0; i < NCOL; i++) load_col(i, $urandom_range(0, 4), $urandom_range(0, 2));
    start_collect(1'b1, 1'b0, tot);
    finish_collect("reverse_done", tot, cyc);

    // Random mixes, including a start pulse while collecting
    for (int it = 0; it < 6; it++) begin
      clear_all();
      rev = 1'($urandom_range(0, 1));
      strict = !rev;
      ready_mode = $urandom_range(0, 1);
      for (int i = 0; i < NCOL; i++) load_col(i, $urandom_range(0, 4), $urandom_range(0, 2));
      start_collect(rev, 1'($urandom_range(0, 1)), tot);
      finish_collect("random", tot, cyc);
    end

    // Counter saturation boundary and sustained throughput
    strict = 1'b1;
    ready_mode = 0;
    clear_all();
    load_col(0, 255, 0);
    for (int i = 1; i < NCOL; i++) load_col(i, 0, 0);
    start_collect(1'b0, 1'b0, tot);
    finish_collect("count_255", tot, cyc);
    clear_all();
    load_col(0, 256, 0);
    for (int i = 1; i < NCOL; i++) load_col(i, 0, 0);
    start_collect(1'b0, 1'b0, tot);
    finish_collect("count_256", tot, cyc);
    chk("throughput", 32'(cyc <= 256 + 4 * NCOL + 8), 32'd1);

    // Reset in the middle of draining a column abandons the list
    clear_all();
    load_col(0, 20, 0);
    for (int i = 1; i < NCOL; i++) load_col(i, 0, 0);
    start_collect(1'b0, 1'b0, tot);
    repeat (6) @(posedge clk);
    #3 reset = 1'b0;
    #1 check_zero("mid_reset");
    clear_all();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("mid_reset_release_rden", 32'(bus.col_rden), 32'd0);
    for (int i = 0; i < NCOL; i++) load_col(i, $urandom_range(1, 3), 0);
    start_collect(1'b0, 1'b0, tot);
    finish_collect("after_reset", tot, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
